// File: rtl/io_bus_responder_pkg.sv
// rtl/io_bus_responder_pkg.sv - shared offsets, CTRL bit positions and bus FSM states
package pa_io_resp;

  localparam logic [2:0] OFS_CTRL     = 3'd0;
  localparam logic [2:0] OFS_STATUS   = 3'd1;
  localparam logic [2:0] OFS_RELOAD_L = 3'd2;
  localparam logic [2:0] OFS_RELOAD_H = 3'd3;
  localparam logic [2:0] OFS_COUNT_L  = 3'd4;
  localparam logic [2:0] OFS_COUNT_H  = 3'd5;
  localparam logic [2:0] OFS_SCRATCH  = 3'd6;
  localparam logic [2:0] OFS_ID       = 3'd7;

  localparam logic [7:0] ID_VALUE = 8'h5A;

  localparam int bitpos_ctrl_tmr_en      = 0;
  localparam int bitpos_ctrl_auto_reload = 1;
  localparam int bitpos_ctrl_irq_en      = 2;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, HOLD} e_bus_state;

endpackage

// File: rtl/io_resp_timer.sv
// rtl/io_resp_timer.sv - 16-bit interval timer with CTRL/STATUS/RELOAD/COUNT registers and irq
module io_resp_timer
  import pa_io_resp::*;
(
  input  logic       clk,
  input  logic       arst,
  input  logic       i_wr,
  input  logic       i_rd,
  input  logic [2:0] i_ofs,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_irq
);

  logic [2:0]  r_ctrl;
  logic        r_expired;
  logic [15:0] r_reload;
  logic [16:0] r_count;
  logic [7:0]  r_snap;

  logic        w_ctrl_wr;
  logic        w_expire;
  logic        w_en_rise;
  logic [2:0]  w_ctrl_nxt;
  logic [16:0] w_reload_val;

  assign w_ctrl_wr    = i_wr & (i_ofs == OFS_CTRL);
  assign w_expire     = r_ctrl[bitpos_ctrl_tmr_en] & (r_count == 17'd1);
  assign w_en_rise    = w_ctrl_wr & i_wdata[bitpos_ctrl_tmr_en] & ~r_ctrl[bitpos_ctrl_tmr_en];
  assign w_reload_val = (r_reload == 16'd0) ? 17'h10000 : {1'b0, r_reload};

  // A CTRL write in the expiry cycle overrides the one-shot auto-disable.
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    if (w_ctrl_wr)
      w_ctrl_nxt = i_wdata[2:0];
    else if (w_expire & ~r_ctrl[bitpos_ctrl_auto_reload])
      w_ctrl_nxt[bitpos_ctrl_tmr_en] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_ctrl    <= 3'd0;
      r_expired <= 1'b0;
      r_reload  <= 16'd0;
      r_count   <= 17'd0;
      r_snap    <= 8'd0;
    end else begin
      r_ctrl <= w_ctrl_nxt;
      if (w_en_rise)
        r_count <= w_reload_val;
      else if (w_expire)
        r_count <= w_ctrl_nxt[bitpos_ctrl_tmr_en] ? w_reload_val : 17'd0;
      else if (r_ctrl[bitpos_ctrl_tmr_en])
        r_count <= r_count - 17'd1;
      if (w_expire)
        r_expired <= 1'b1;
      else if (i_wr & (i_ofs == OFS_STATUS) & i_wdata[0])
        r_expired <= 1'b0;
      if (i_wr & (i_ofs == OFS_RELOAD_L))
        r_reload[7:0] <= i_wdata;
      if (i_wr & (i_ofs == OFS_RELOAD_H))
        r_reload[15:8] <= i_wdata;
      if (i_rd & (i_ofs == OFS_COUNT_L))
        r_snap <= r_count[15:8];
    end
  end

  always_comb begin
    o_rdata = 8'd0;
    case (i_ofs)
      OFS_CTRL:     o_rdata = {5'd0, r_ctrl};
      OFS_STATUS:   o_rdata = {7'd0, r_expired};
      OFS_RELOAD_L: o_rdata = r_reload[7:0];
      OFS_RELOAD_H: o_rdata = r_reload[15:8];
      OFS_COUNT_L:  o_rdata = r_count[7:0];
      OFS_COUNT_H:  o_rdata = r_snap;
      default:      o_rdata = 8'd0;
    endcase
  end

  assign o_irq = r_expired & r_ctrl[bitpos_ctrl_irq_en];

endmodule

// File: rtl/io_bus_responder.sv
// rtl/io_bus_responder.sv - IO-window bus target with wait states; timer built under IO_RESP_TIMER_EN
module io_bus_responder
  import pa_io_resp::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF80,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [21:0] address,
  input  logic        rd,
  input  logic        wr,
  input  logic        mem_io,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        wait_req,
  output logic        irq_out
);

  localparam logic [3:0] LP_WS     = 4'(WAIT_STATES);
  localparam logic       LP_DIRECT = (WAIT_STATES <= 1);
  localparam logic       LP_HAS_WS = (WAIT_STATES != 0);

  e_bus_state r_state, w_state_nxt;
  logic [3:0] r_wcnt, w_wcnt_nxt;
  logic [7:0] r_data_out, r_scratch;
  logic       r_data_oe;
  logic       w_hit, w_wr_commit, w_rd_commit, w_irq;
  logic [2:0] w_ofs;
  logic [7:0] w_rdata, w_tmr_rdata;
  logic       w_unused;

  assign w_hit    = ~mem_io & (address[15:3] == BASE_ADDR[15:3]) & (~rd | ~wr);
  assign w_ofs    = address[2:0];
  assign w_unused = ^address[21:16];

  // The first hit cycle already counts as one wait state, so WAIT covers the rest.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    wait_req    = 1'b0;
    w_wr_commit = 1'b0;
    w_rd_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          wait_req    = LP_HAS_WS;
          w_wcnt_nxt  = LP_WS;
          w_state_nxt = LP_DIRECT ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        wait_req = 1'b1;
        if (!w_hit) begin
          w_state_nxt = IDLE;
        end else begin
          w_wcnt_nxt = r_wcnt - 4'd1;
          if (r_wcnt == 4'd2)
            w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (w_hit) begin
          if (!rd) w_rd_commit = 1'b1;
          else     w_wr_commit = 1'b1;
        end
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (rd && wr)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (arst) begin
      wait_req    = 1'b0;
      w_wr_commit = 1'b0;
      w_rd_commit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state    <= IDLE;
      r_wcnt     <= 4'd0;
      r_data_out <= 8'd0;
      r_data_oe  <= 1'b0;
      r_scratch  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_rd_commit) begin
        r_data_out <= w_rdata;
        r_data_oe  <= 1'b1;
      end else begin
        r_data_oe <= r_data_oe & (r_state == HOLD) & ~(rd & wr);
      end
      if (w_wr_commit && (w_ofs == OFS_SCRATCH))
        r_scratch <= data_in;
    end
  end

  always_comb begin
    w_rdata = 8'd0;
    case (w_ofs)
      OFS_SCRATCH: w_rdata = r_scratch;
      OFS_ID:      w_rdata = ID_VALUE;
      default:     w_rdata = w_tmr_rdata;
    endcase
  end

`ifdef IO_RESP_TIMER_EN
  io_resp_timer u_timer (
    .clk     (clk),
    .arst    (arst),
    .i_wr    (w_wr_commit),
    .i_rd    (w_rd_commit),
    .i_ofs   (w_ofs),
    .i_wdata (data_in),
    .o_rdata (w_tmr_rdata),
    .o_irq   (w_irq)
  );
`else
  assign w_tmr_rdata = 8'd0;
  assign w_irq       = 1'b0;
`endif

  assign data_out = r_data_out;
  assign data_oe  = r_data_oe;
  assign irq_out  = w_irq;

endmodule
